alu_op_issue: RTL and testbench

- Decode/issue stage that produces the 4-bit ALU operation code and operand-select for the ALU, from a raw RV32 instruction word.
- Sits between the fetch/decode front end and the ALU: upstream valid/ready on the instruction, registered downstream valid/ready toward execute.
- Two-entry skid buffer: full throughput, 1-cycle latency, no combinational ready path upstream.

---
 rtl/alu_op_issue.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_op_issue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// alu_op_issue: decode/issue stage producing the 4-bit ALU operation code and the
// operand-B select from a raw RV32 instruction word.
//
// The upstream side uses valid/ready. The downstream side is fully registered and also
// uses valid/ready. A two-entry skid buffer (output register plus one skid entry) gives
// full throughput and 1-cycle latency. in_ready comes straight from a flop, so there is
// no combinational path from out_ready to in_ready.
//
// Optional feature: define ALU_OP_ISSUE_ZBB_EN to decode clz/ctz/cpop (alu_control
// 1000/1001/1010). When it is undefined, those encodings are illegal and alu_control
// never exceeds 0111.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous flush of the output register and skid entry
//   in_valid     instruction word valid
//   in_ready     stage can accept an instruction (registered)
//   instr        RV32 instruction word
//   out_valid    decoded op valid
//   out_ready    execute stage accepts the op
//   alu_control  ALU operation code
//   alu_src_imm  1 = operand B is the immediate
//   illegal      instruction not supported by the ALU
//   ill_count    saturating count of illegal ops delivered downstream
module alu_op_issue #(
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_control,
    output logic                 alu_src_imm,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    // Major opcodes
    localparam logic [6:0] OpcReg    = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    // ALU operation codes
    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSlt  = 4'b0101;
    localparam logic [3:0] AluSll  = 4'b0110;
    localparam logic [3:0] AluSrl  = 4'b0111;
`ifdef ALU_OP_ISSUE_ZBB_EN
    localparam logic [3:0] AluClz  = 4'b1000;
    localparam logic [3:0] AluCtz  = 4'b1001;
    localparam logic [3:0] AluCpop = 4'b1010;
`endif

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
`ifdef ALU_OP_ISSUE_ZBB_EN
    localparam logic [6:0] F7Zbb  = 7'b0110000;
`endif

    typedef struct packed {
        logic [3:0] ctl;
        logic       imm;
        logic       ill;
    } op_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs2_field;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign rs2_field = instr[24:20];

    // rs1/rd fields never influence the ALU op; rs2 only matters with the Zbb decode.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[19:15], instr[11:7], rs2_field};

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [3:0] raw_ctl;
    logic       raw_imm;
    logic       raw_ill;
    op_t        dec_op;

    always_comb begin
        raw_ctl = AluAdd;
        raw_imm = 1'b0;
        raw_ill = 1'b0;
        case (opcode)
            OpcReg: begin
                if (funct7 == F7Base) begin
                    case (funct3)
                        3'b000:  raw_ctl = AluAdd;
                        3'b001:  raw_ctl = AluSll;
                        3'b010:  raw_ctl = AluSlt;
                        3'b100:  raw_ctl = AluXor;
                        3'b101:  raw_ctl = AluSrl;
                        3'b110:  raw_ctl = AluOr;
                        3'b111:  raw_ctl = AluAnd;
                        default: raw_ill = 1'b1;
                    endcase
                end else if (funct7 == F7Alt && funct3 == 3'b000) begin
                    raw_ctl = AluSub;
                end else begin
                    // sra and every other alternate-funct7 form
                    raw_ill = 1'b1;
                end
            end
            OpcImm: begin
                raw_imm = 1'b1;
                case (funct3)
                    3'b000: raw_ctl = AluAdd;
                    3'b010: raw_ctl = AluSlt;
                    3'b100: raw_ctl = AluXor;
                    3'b110: raw_ctl = AluOr;
                    3'b111: raw_ctl = AluAnd;
                    3'b001: begin
                        if (funct7 == F7Base) begin
                            raw_ctl = AluSll;
`ifdef ALU_OP_ISSUE_ZBB_EN
                        end else if (funct7 == F7Zbb) begin
                            // Unary bit-count ops read only rs1
                            raw_imm = 1'b0;
                            case (rs2_field)
                                5'b00000: raw_ctl = AluClz;
                                5'b00001: raw_ctl = AluCtz;
                                5'b00010: raw_ctl = AluCpop;
                                default:  raw_ill = 1'b1;
                            endcase
`endif
                        end else begin
                            raw_ill = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7Base) begin
                            raw_ctl = AluSrl;
                        end else begin
                            raw_ill = 1'b1;
                        end
                    end
                    default: raw_ill = 1'b1;
                endcase
            end
            OpcLoad, OpcStore, OpcJalr: begin
                // Address generation: rs1 + immediate
                raw_ctl = AluAdd;
                raw_imm = 1'b1;
            end
            OpcBranch: begin
                raw_ctl = AluSub;
            end
            default: raw_ill = 1'b1;
        endcase

        // Illegal ops always present a neutral add with register operands
        dec_op.ill = raw_ill;
        dec_op.ctl = raw_ill ? AluAdd : raw_ctl;
        dec_op.imm = raw_ill ? 1'b0 : raw_imm;
    end

    // ------------------------------------------------------------------
    // Two-entry skid buffer
    // ------------------------------------------------------------------
    logic out_valid_q;
    op_t  out_op_q;
    logic skid_valid_q;
    op_t  skid_op_q;
    logic accept;
    logic drain;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_op_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_op_q    <= '0;
        end else if (flush) begin
            // Flush wins over any accept or transfer this cycle
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output register is free after this edge
            if (skid_valid_q) begin
                // in_ready is low here, so no new op can arrive alongside
                out_op_q     <= skid_op_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_op_q    <= dec_op;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the op in the skid entry
            skid_op_q    <= dec_op;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_control = out_op_q.ctl;
    assign alu_src_imm = out_op_q.imm;
    assign illegal     = out_op_q.ill;

    // ------------------------------------------------------------------
    // Saturating illegal-op counter
    // ------------------------------------------------------------------
    logic [ILL_CNT_W-1:0] ill_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_count_q <= '0;
        end else if (drain && !flush && out_op_q.ill && (ill_count_q != '1)) begin
            ill_count_q <= ill_count_q + ILL_CNT_W'(1);
        end
    end

    assign ill_count = ill_count_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: directed steps plus random traffic, checked
// against a queue-based model of the two-entry buffer and a table-driven decode.
module tb_alu_op_issue;

    localparam int unsigned CntW   = 8;
    localparam int          CntMax = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_control;
    logic            alu_src_imm;
    logic            illegal;
    logic [CntW-1:0] ill_count;

    alu_op_issue #(.ILL_CNT_W(CntW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_control(alu_control),
        .alu_src_imm(alu_src_imm),
        .illegal    (illegal),
        .ill_count  (ill_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: ops held by the stage in delivery order, each {ill, imm, ctl[3:0]}
    logic [5:0] q[$];
    int         ill_model = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: {ill, imm, ctl}
    function automatic logic [5:0] ref_decode(input logic [31:0] w);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] sh;
        int         r_code[8];
        int         i_code[8];
        opc    = w[6:0];
        f3     = w[14:12];
        f7     = w[31:25];
        sh     = w[24:20];
        // funct3 -> op for the base register/immediate forms; -1 = not listed
        r_code = '{0, 6, 5, -1, 4, 7, 3, 2};
        i_code = '{0, -1, 5, -1, 4, -1, 3, 2};
        if (opc == 7'h03 || opc == 7'h23 || opc == 7'h67) return 6'b01_0000;
        if (opc == 7'h63) return 6'b00_0001;
        if (opc == 7'h33) begin
            if (f7 == 7'h00 && r_code[f3] >= 0) return {2'b00, 4'(r_code[f3])};
            if (f7 == 7'h20 && f3 == 3'd0) return 6'b00_0001;
            return 6'b10_0000;
        end
        if (opc == 7'h13) begin
            if (i_code[f3] >= 0) return {2'b01, 4'(i_code[f3])};
            if (f3 == 3'd1 && f7 == 7'h00) return 6'b01_0110;
            if (f3 == 3'd5 && f7 == 7'h00) return 6'b01_0111;
`ifdef ALU_OP_ISSUE_ZBB_EN
            if (f3 == 3'd1 && f7 == 7'h30 && sh < 5'd3) return {2'b00, 4'(8 + int'(sh))};
`endif
            return 6'b10_0000;
        end
        return 6'b10_0000;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs[7];
        logic [6:0] f7s[3];
        logic [31:0] w;
        int k;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h63, 7'h00};
        f7s  = '{7'h00, 7'h20, 7'h30};
        w = $urandom;
        k = $urandom_range(0, 7);
        w[6:0] = (k == 7) ? 7'($urandom) : opcs[k];
        k = $urandom_range(0, 3);
        w[31:25] = (k == 3) ? 7'($urandom) : f7s[k];
        if ($urandom_range(0, 3) != 0) w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // One clock: compare outputs against the model, take the edge, advance the model.
    // Called #1 after an edge with inputs already driven.
    task automatic cycle();
        logic exp_ready;
        logic acc;
        logic drn;
        exp_ready = (q.size() < 2);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) check("out_op", {26'd0, illegal, alu_src_imm, alu_control}, 32'(q[0]));
        check("ill_count", 32'(ill_count), 32'(ill_model));
        acc = in_valid && exp_ready;
        drn = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (drn) begin
                if (q[0][5] && ill_model < CntMax) ill_model++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(ref_decode(instr));
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic rdy);
        in_valid  = v;
        instr     = w;
        out_ready = rdy;
        flush     = 1'b0;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'h0, 1'b1);
        repeat (n) cycle();
    endtask

    task automatic check_out(input string tag, input logic [3:0] ctl, input logic imm,
                             input logic ill);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_op"}, {26'd0, illegal, alu_src_imm, alu_control}, {26'd0, ill, imm, ctl});
    endtask

    initial begin
        int saved_cnt;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op", {26'd0, illegal, alu_src_imm, alu_control}, 32'd0);
        check("rst_ill_count", 32'(ill_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single add, one-cycle latency
        drive(1'b1, 32'h003100B3, 1'b1);
        cycle();
        check_out("add", 4'b0000, 1'b0, 1'b0);
        idle(2);

        // Back-to-back sub, lw, beq
        drive(1'b1, 32'h403100B3, 1'b1);
        cycle();
        check_out("sub", 4'b0001, 1'b0, 1'b0);
        drive(1'b1, 32'h00012083, 1'b1);
        cycle();
        check_out("lw", 4'b0000, 1'b1, 1'b0);
        check("stream_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h00310063, 1'b1);
        cycle();
        check_out("beq", 4'b0001, 1'b0, 1'b0);
        check("stream_in_ready2", 32'(in_ready), 32'd1);
        idle(2);

        // Zbb encodings
        drive(1'b1, 32'h60011093, 1'b1);
        cycle();
`ifdef ALU_OP_ISSUE_ZBB_EN
        check_out("clz", 4'b1000, 1'b0, 1'b0);
`else
        check_out("clz_off", 4'b0000, 1'b0, 1'b1);
`endif
        drive(1'b1, 32'h60211093, 1'b1);
        cycle();
`ifdef ALU_OP_ISSUE_ZBB_EN
        check_out("cpop", 4'b1010, 1'b0, 1'b0);
`else
        check_out("cpop_off", 4'b0000, 1'b0, 1'b1);
`endif
        idle(2);

        // Stall: three ops offered, two held, in order on release
        drive(1'b1, 32'h403100B3, 1'b0);
        cycle();
        drive(1'b1, 32'h00012083, 1'b0);
        cycle();
        check("stall_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h0031F0B3, 1'b0);
        cycle();
        check("stall_hold", {28'd0, alu_control}, 32'd1);
        drive(1'b0, 32'h0, 1'b1);
        cycle();
        check_out("stall_second", 4'b0000, 1'b1, 1'b0);
        check("stall_ready_back", 32'(in_ready), 32'd1);
        idle(2);

        // Flush with two buffered ops and a new op presented
        drive(1'b1, 32'h403150B3, 1'b0);
        cycle();
        drive(1'b1, 32'hFFFFFFFF, 1'b0);
        cycle();
        saved_cnt = int'(ill_count);
        drive(1'b1, 32'h003100B3, 1'b0);
        flush = 1'b1;
        cycle();
        drive(1'b0, 32'h0, 1'b1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_ill_count", 32'(ill_count), 32'(saved_cnt));
        idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 6);
            if ($urandom_range(0, 29) == 0) begin
                flush     = 1'b1;
                out_ready = 1'b0;
            end
            cycle();
        end
        idle(3);

        // Saturation: 300 sra
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'h403150B3, 1'b1);
            cycle();
            check("sra_illegal", 32'(illegal), 32'd1);
        end
        idle(3);
        check("ill_sat", 32'(ill_count), 32'd255);

        // Asynchronous reset with ops buffered
        drive(1'b1, 32'h003100B3, 1'b0);
        repeat (2) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_ill_count", 32'(ill_count), 32'd0);
        q.delete();
        ill_model = 0;
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
